// File: rtl/sample_msg_merger_pkg.sv
// rtl/sample_msg_merger_pkg.sv - framing constants and state types shared by the merger and the far-end splitter
package sample_msg_merger_pkg;

  localparam int MSG_LENGTH_WIDTH = 8;

  typedef enum logic [1:0] {EXPECT_HDR, EXPECT_BODY, DROP_BODY} chk_state_t;
  typedef enum logic {IDLE, MSG} sched_state_t;

  function automatic int flag_bit(input int width);
    return width - 1;
  endfunction

  // Header length field sits directly below the flag bit.
  function automatic int len_msb(input int width);
    return width - 2;
  endfunction

endpackage

// File: rtl/sample_msg_merger_sync_fifo.sv
// rtl/sample_msg_merger_sync_fifo.sv - first-word-fall-through synchronous fifo with occupancy count
module sample_msg_merger_sync_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 empty,
  output logic                 full,
  output logic [DEPTH_LOG:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic                 do_wr;
  logic                 do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG+1)'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
      if (do_rd) rd_ptr <= rd_ptr + DEPTH_LOG'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (DEPTH_LOG+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sample_msg_merger.sv
// rtl/sample_msg_merger.sv - merges a sample stream and atomic message packets onto one link with alternating fairness
module sample_msg_merger
  import sample_msg_merger_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int SAMPLE_BUF_LOG = 4,
  parameter int MSG_BUF_LOG    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_samples,
  input  logic             in_samples_nd,
  input  logic [WIDTH-1:0] in_msg,
  input  logic             in_msg_nd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nd,
  output logic             sample_overflow,
  output logic             msg_overflow,
  output logic             error
);

  localparam int FLAG      = flag_bit(WIDTH);
  localparam int LMSB      = len_msb(WIDTH);
  localparam int MSG_DEPTH = 1 << MSG_BUF_LOG;

  typedef logic [MSG_LENGTH_WIDTH-1:0] len_t;

  logic                    s_wr, s_rd, s_empty, s_full;
  logic [WIDTH-1:0]        s_head;
  logic [SAMPLE_BUF_LOG:0] s_count;
  logic                    m_wr, m_rd, m_empty, m_full;
  logic [WIDTH-1:0]        m_head;
  logic [MSG_BUF_LOG:0]    m_count;
  logic                    unused_fifo_status;

  assign unused_fifo_status = ^{s_count, m_full};

  sample_msg_merger_sync_fifo #(.WIDTH(WIDTH), .DEPTH_LOG(SAMPLE_BUF_LOG)) u_sample_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(s_wr), .wr_data(in_samples), .rd_en(s_rd),
    .rd_data(s_head), .empty(s_empty), .full(s_full), .count(s_count)
  );

  sample_msg_merger_sync_fifo #(.WIDTH(WIDTH), .DEPTH_LOG(MSG_BUF_LOG)) u_msg_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(m_wr), .wr_data(in_msg), .rd_en(m_rd),
    .rd_data(m_head), .empty(m_empty), .full(m_full), .count(m_count)
  );

  logic s_bad, s_drop;
  assign s_bad  = in_samples_nd &&  in_samples[FLAG];
  assign s_drop = in_samples_nd && !in_samples[FLAG] && s_full;
  assign s_wr   = in_samples_nd && !in_samples[FLAG] && !s_full;

  chk_state_t chk_state;
  len_t       chk_rem;
  len_t       in_len;
  logic       m_is_hdr, m_fits, m_bad, m_ovf;

  assign m_is_hdr = in_msg[FLAG];
  assign in_len   = in_msg[LMSB -: MSG_LENGTH_WIDTH];
  // Space for the whole packet is reserved up front, so body words never meet a full buffer.
  assign m_fits   = (32'(in_len) + 32'd1) <= (32'(MSG_DEPTH) - 32'(m_count));

  always_comb begin
    m_wr  = 1'b0;
    m_bad = 1'b0;
    m_ovf = 1'b0;
    if (in_msg_nd) begin
      case (chk_state)
        EXPECT_HDR: begin
          if (!m_is_hdr)   m_bad = 1'b1;
          else if (m_fits) m_wr  = 1'b1;
          else             m_ovf = 1'b1;
        end
        EXPECT_BODY: begin
          if (m_is_hdr) m_bad = 1'b1;
          else          m_wr  = 1'b1;
        end
        default: m_bad = m_is_hdr;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_state <= EXPECT_HDR;
      chk_rem   <= '0;
    end else if (in_msg_nd) begin
      if (chk_state == EXPECT_HDR) begin
        if (m_is_hdr && in_len != '0) begin
          chk_state <= m_fits ? EXPECT_BODY : DROP_BODY;
          chk_rem   <= in_len;
        end
      end else if (!m_is_hdr) begin
        chk_rem <= chk_rem - len_t'(1);
        if (chk_rem == len_t'(1)) chk_state <= EXPECT_HDR;
      end
    end
  end

  sched_state_t sched_state;
  len_t         sched_rem;
  len_t         head_len;
  logic         last_was_msg;
  logic         take_msg, take_sample;

  assign head_len = m_head[LMSB -: MSG_LENGTH_WIDTH];
  assign m_rd     = take_msg;
  assign s_rd     = take_sample;

  always_comb begin
    take_msg    = 1'b0;
    take_sample = 1'b0;
    if (sched_state == MSG)
      take_msg = !m_empty;
    else if (!m_empty && m_head[FLAG] && (!last_was_msg || s_empty))
      take_msg = 1'b1;
    else
      take_sample = !s_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched_state     <= IDLE;
      sched_rem       <= '0;
      last_was_msg    <= 1'b0;
      out_data        <= '0;
      out_nd          <= 1'b0;
      sample_overflow <= 1'b0;
      msg_overflow    <= 1'b0;
      error           <= 1'b0;
    end else begin
      out_nd <= take_msg || take_sample;
      if (take_msg)         out_data <= m_head;
      else if (take_sample) out_data <= s_head;

      case (sched_state)
        IDLE: begin
          if (take_msg) begin
            if (head_len != '0) begin
              sched_state <= MSG;
              sched_rem   <= head_len;
            end else begin
              last_was_msg <= 1'b1;
            end
          end else if (take_sample) begin
            last_was_msg <= 1'b0;
          end
        end
        default: begin
          if (take_msg) begin
            sched_rem <= sched_rem - len_t'(1);
            if (sched_rem == len_t'(1)) begin
              sched_state  <= IDLE;
              last_was_msg <= 1'b1;
            end
          end
        end
      endcase

      sample_overflow <= sample_overflow | s_drop;
      msg_overflow    <= msg_overflow | m_ovf;
      error           <= error | s_bad | s_drop | m_bad | m_ovf;
    end
  end

endmodule
